// File: rtl/atto_pe_injector.sv
// PE-side injector: buffers PE send requests in a small FIFO and launches each
// one to the router as a 48-bit flit, signalled by inverting a two-wire event pair.
module atto_pe_injector #(
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_dest_x,
    input  logic [3:0]  req_dest_y,
    input  logic [39:0] req_payload,
    output logic [47:0] pe_channel_dout,
    output logic [1:0]  pe_diff_pair_dout,
    input  logic        r2pe_ack_din,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clear,
    output logic [15:0] flit_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;

    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    state_t        state_reg;
    logic [WW-1:0] wait_cnt_reg;
    logic [GW-1:0] gap_cnt_reg;

    logic        push;
    logic        pop;
    logic        set_err;
    logic [47:0] head;

    assign req_ready = (count_reg != FULL_COUNT);
    assign push      = req_valid & req_ready;
    assign pop       = (state_reg == IDLE) && (count_reg != '0);
    assign head      = mem[rd_ptr_reg];
    assign set_err   = (state_reg == WAIT_ACK) && (wait_cnt_reg == WAIT_LAST);
    assign busy      = (count_reg != '0) | (state_reg != IDLE);

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clka) begin
        if (push) begin
            mem[wr_ptr_reg] <= {req_dest_x, req_dest_y, req_payload};
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state_reg         <= IDLE;
            pe_channel_dout   <= '0;
            pe_diff_pair_dout <= 2'b10;
            wait_cnt_reg      <= '0;
            gap_cnt_reg       <= '0;
            timeout_err       <= 1'b0;
            flit_count        <= '0;
        end else begin
            if (set_err) begin
                timeout_err <= 1'b1;
            end else if (err_clear) begin
                timeout_err <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        pe_channel_dout   <= head;
                        pe_diff_pair_dout <= ~pe_diff_pair_dout;
                        wait_cnt_reg      <= '0;
                        state_reg         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (wait_cnt_reg != WAIT_MAX) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                    // No relaunch after a timeout: re-toggling would duplicate the flit.
                    if (r2pe_ack_din) begin
                        flit_count <= flit_count + 16'd1;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_reg <= GAP_LOAD;
                            state_reg   <= GAP;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                GAP: begin
                    gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    if (gap_cnt_reg == GW'(1)) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atto_pe_injector.sv
// Randomized scoreboard bench for atto_pe_injector with a queue-based reference model.
module tb_atto_pe_injector;

    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 8;
    localparam int GAP_CYCLES = 1;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_dest_x = '0;
    logic [3:0]  req_dest_y = '0;
    logic [39:0] req_payload = '0;
    logic [47:0] pe_channel_dout;
    logic [1:0]  pe_diff_pair_dout;
    logic        r2pe_ack_din = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic        err_clear = 1'b0;
    logic [15:0] flit_count;

    int checks   = 0;
    int failures = 0;

    atto_pe_injector #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clka(clka), .rsta(rsta),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_payload(req_payload),
        .pe_channel_dout(pe_channel_dout), .pe_diff_pair_dout(pe_diff_pair_dout),
        .r2pe_ack_din(r2pe_ack_din), .busy(busy), .timeout_err(timeout_err),
        .err_clear(err_clear), .flit_count(flit_count)
    );

    always #5 clka = ~clka;

    // Reference model: phase 0 = idle, 1 = waiting for ack, 2 = post-ack gap.
    logic [47:0] m_q[$];
    logic [47:0] exp_q[$];
    int          m_phase, m_wait, m_gap;
    logic [47:0] m_chan;
    logic [1:0]  m_pair;
    logic        m_err;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_phase = 0; m_wait = 0; m_gap = 0;
        m_chan = '0; m_pair = 2'b10; m_err = 1'b0; m_cnt = '0;
    endtask

    task automatic model_step();
        int   sz;
        bit   push, set_err;
        sz      = m_q.size();
        push    = req_valid && (sz < DEPTH);
        set_err = 0;
        case (m_phase)
            0: if (sz > 0) begin
                m_chan  = m_q.pop_front();
                m_pair  = ~m_pair;
                m_wait  = 0;
                m_phase = 1;
            end
            1: begin
                if (m_wait < TIMEOUT) begin
                    m_wait++;
                    if (m_wait == TIMEOUT) set_err = 1;
                end
                if (r2pe_ack_din) begin
                    m_cnt++;
                    if (GAP_CYCLES > 0) begin m_phase = 2; m_gap = 0; end
                    else m_phase = 0;
                end
            end
            default: begin
                m_gap++;
                if (m_gap >= GAP_CYCLES) m_phase = 0;
            end
        endcase
        if (set_err) m_err = 1'b1;
        else if (err_clear) m_err = 1'b0;
        if (push) begin
            m_q.push_back({req_dest_x, req_dest_y, req_payload});
            exp_q.push_back({req_dest_x, req_dest_y, req_payload});
        end
    endtask

    task automatic tick();
        @(posedge clka);
        if (rsta) model_step();
        #1;
    endtask

    task automatic rand_req(input bit valid);
        req_valid   = valid;
        req_dest_x  = 4'($urandom_range(0, 15));
        req_dest_y  = 4'($urandom_range(0, 15));
        req_payload = {8'($urandom), 32'($urandom)};
    endtask

    task automatic do_reset(input int n);
        rsta = 1'b0;
        model_reset();
        req_valid = 1'b0; r2pe_ack_din = 1'b0; err_clear = 1'b0;
        repeat (n) tick();
        rsta = 1'b1;
        check("rst_pair", pe_diff_pair_dout, 2'b10);
        check("rst_channel", pe_channel_dout, 48'h0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", flit_count, 16'h0);
        check("rst_err", timeout_err, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        err_clear = 1'b0;
        while (!(m_phase == 0 && m_q.size() == 0) && n < 200) begin
            r2pe_ack_din = (m_phase == 1);
            tick();
            n++;
        end
        r2pe_ack_din = 1'b0;
        if (n >= 200) check("drain_timeout", 1'b0, 1'b1);
    endtask

    // Scoreboard monitor: every pair inversion is a new flit and must match the next accepted request.
    logic [1:0] last_pair = 2'b10;
    always @(negedge clka) begin
        logic [47:0] exp;
        if (!rsta) begin
            last_pair = 2'b10;
        end else begin
            if (pe_diff_pair_dout !== last_pair) begin
                if (exp_q.size() == 0) begin
                    check("flit_unexpected", 1'b1, 1'b0);
                end else begin
                    exp = exp_q.pop_front();
                    check("flit_data", pe_channel_dout, exp);
                end
                last_pair = pe_diff_pair_dout;
            end
            check("pair", pe_diff_pair_dout, m_pair);
            check("channel", pe_channel_dout, m_chan);
            check("ready", req_ready, m_q.size() < DEPTH);
            check("busy", busy, (m_q.size() != 0) || (m_phase != 0));
            check("flit_count", flit_count, m_cnt);
            check("timeout_err", timeout_err, m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] held;
        logic [15:0] saved_cnt;

        do_reset(5);

        // Single flit with a late ack.
        req_valid = 1'b1; req_dest_x = 4'd2; req_dest_y = 4'd1; req_payload = 40'h0;
        tick();
        req_valid = 1'b0;
        tick();
        check("single_channel", pe_channel_dout, 48'h210000000000);
        check("single_pair", pe_diff_pair_dout, 2'b01);
        tick(); tick();
        r2pe_ack_din = 1'b1;
        tick();
        r2pe_ack_din = 1'b0;
        check("single_count", flit_count, 16'd1);
        check("single_gap_busy", busy, 1'b1);
        tick();
        check("single_idle_busy", busy, 1'b0);

        // Back-to-back pushes until the FIFO is full.
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            rand_req(1'b1);
            tick();
        end
        req_valid = 1'b0;
        check("b2b_full_ready", req_ready, 1'b0);
        for (int n = 0; n < 100 && !(m_phase == 0 && m_q.size() == 0); n++) begin
            r2pe_ack_din = (m_phase == 1) && (m_wait >= 1);
            tick();
        end
        r2pe_ack_din = 1'b0;
        check("b2b_count", flit_count, 16'd5);
        check("b2b_pair", pe_diff_pair_dout, 2'b01);

        // Channel and pair stay frozen while the ack is withheld.
        do_reset(2);
        rand_req(1'b1);
        held = {req_dest_x, req_dest_y, req_payload};
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 50; i++) begin
            rand_req(1'($urandom_range(0, 1)));
            tick();
            if (i % 10 == 0) begin
                check("hold_channel", pe_channel_dout, held);
                check("hold_pair", pe_diff_pair_dout, 2'b01);
            end
        end
        drain();

        // Timeout sets after TIMEOUT waiting cycles, survives the ack, then clears.
        do_reset(2);
        rand_req(1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        check("to_not_yet", timeout_err, 1'b0);
        tick();
        check("to_set", timeout_err, 1'b1);
        r2pe_ack_din = 1'b1;
        tick();
        r2pe_ack_din = 1'b0;
        check("to_ack_count", flit_count, 16'd1);
        check("to_sticky", timeout_err, 1'b1);
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("to_cleared", timeout_err, 1'b0);

        // Set and clear on the same edge: set wins.
        rand_req(1'b1);
        tick();
        req_valid = 1'b0;
        for (int n = 0; n < 20 && !(m_phase == 1 && m_wait == TIMEOUT - 1); n++) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("to_set_wins", timeout_err, 1'b1);
        drain();

        // Acks while idle are ignored.
        saved_cnt = m_cnt;
        r2pe_ack_din = 1'b1;
        repeat (3) tick();
        r2pe_ack_din = 1'b0;
        check("spurious_count", flit_count, saved_cnt);
        check("spurious_err_idle", busy, 1'b0);

        // Reset asserted mid-flit acts immediately.
        rand_req(1'b1);
        tick();
        rand_req(1'b1);
        tick(); tick();
        #3;
        rsta = 1'b0;
        #1;
        check("midrst_pair", pe_diff_pair_dout, 2'b10);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        check("midrst_count", flit_count, 16'h0);
        do_reset(2);

        // Random traffic with random acks (including spurious ones) and clears.
        for (int i = 0; i < 600; i++) begin
            rand_req($urandom_range(0, 99) < 40);
            r2pe_ack_din = ($urandom_range(0, 99) < 30);
            err_clear    = ($urandom_range(0, 99) < 5);
            tick();
        end
        drain();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atto_pe_injector.md
Name: atto_pe_injector

Overview:
PE-side network interface that sits directly upstream of the atto router's PE input port. It accepts PE send requests (destination plus 40-bit payload) through a valid/ready handshake and buffers them in a small FIFO. It builds 48-bit flits and presents each one to the router on pe_channel_din/pe_diff_pair_din using transition signalling, holding each flit until the router returns r2pe_ack_dout.

Parameters:
DEPTH, 4, request FIFO entries; power of two, minimum 2
TIMEOUT, 255, WAIT_ACK cycles before timeout_err sets; minimum 1
GAP_CYCLES, 1, idle cycles forced after each ack before the next launch; 0 allowed

Ports:
clka  in  1  clock; all state updates on rising edge
rsta  in  1  reset, asynchronous, active-low
req_valid  in  1  PE request valid
req_ready  out  1  injector can accept a request
req_dest_x  in  4  destination column
req_dest_y  in  4  destination row
req_payload  in  40  payload
pe_channel_dout  out  48  flit to router pe_channel_din
pe_diff_pair_dout  out  2  flit-event pair to router pe_diff_pair_din
r2pe_ack_din  in  1  acceptance pulse from router r2pe_ack_dout
busy  out  1  FIFO non-empty or FSM not in IDLE
timeout_err  out  1  sticky ack-timeout flag
err_clear  in  1  clears timeout_err
flit_count  out  16  acknowledged flits, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (rsta=0, asynchronous): FIFO empty; FSM = IDLE; pe_channel_dout = 48'h0; pe_diff_pair_dout = 2'b10; timeout_err = 0; flit_count = 0; busy = 0. Requests are ignored while rsta = 0. If reset asserts mid-flit, the flit is abandoned and the pair returns to 2'b10.
- Flit format: [47:44] = req_dest_x, [43:40] = req_dest_y, [39:0] = req_payload.
- Pair encoding: only the legal values 2'b10 and 2'b01 are driven. Each new flit is signalled by inverting the pair (10<->01) in the same cycle that pe_channel_dout loads. The pair never changes at any other time.
- FIFO:
  - req_ready = !full, combinational from the occupancy count.
  - A push occurs when req_valid & req_ready.
  - Pop and push in the same cycle are allowed, and occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
  - When full, req_ready = 0; a pop in that cycle does not raise req_ready until the next cycle.
- FSM states IDLE, WAIT_ACK, GAP:
  - IDLE:
    - If the FIFO is non-empty: load the head flit into pe_channel_dout, toggle the pair, pop, clear the wait counter, and go to WAIT_ACK.
    - Latency: a request pushed into an empty FIFO at edge N appears on pe_channel_dout after edge N+1.
  - WAIT_ACK:
    - pe_channel_dout and the pair are held stable.
    - The wait counter increments each cycle and saturates at TIMEOUT.
    - When the counter reaches TIMEOUT, timeout_err sets. The FSM stays in WAIT_ACK and there is no retransmission, because a re-toggle would duplicate the flit.
    - On r2pe_ack_din = 1: flit_count increments, then go to GAP (GAP_CYCLES > 0) or IDLE (GAP_CYCLES = 0).
    - An ack arriving in the same cycle the counter hits TIMEOUT still completes the flit, and timeout_err still sets.
  - GAP:
    - Count GAP_CYCLES cycles, then go to IDLE.
    - The channel keeps its last value (no clearing to zero).
  - r2pe_ack_din in IDLE or GAP is ignored: no count change and no error.
- timeout_err:
  - err_clear = 1 clears it on the next edge.
  - If a set and err_clear occur in the same cycle, the set wins.
- busy = (occupancy != 0) | (state != IDLE).

Test Plan:
- Reset values: hold rsta=0 for 5 cycles, then release -> pe_diff_pair_dout=2'b10, pe_channel_dout=0, req_ready=1, busy=0, flit_count=0.
- Single flit: push dest (2,1), payload 40'h0 -> one cycle later pe_channel_dout=48'h210000000000, pair=2'b01; ack pulse 3 cycles later -> flit_count=1; with GAP_CYCLES=1, IDLE is reached 1 cycle after the ack.
- Back-to-back: push 5 requests with DEPTH=4 and no ack -> first pops to channel, 4 fill the FIFO, req_ready=0. Ack each after 2 cycles -> pair sequence 01,10,01,10,01; payloads emerge in push order; flit_count=5.
- Hold stability: withhold ack 50 cycles while changing req_* inputs -> pe_channel_dout and pair unchanged throughout.
- Timeout: TIMEOUT=8, no ack -> timeout_err=1 after 8 WAIT_ACK cycles. Then ack -> flit_count increments while timeout_err stays 1. Then err_clear -> timeout_err=0.
- Spurious ack and mid-flight reset: ack in IDLE -> flit_count unchanged. Assert rsta during WAIT_ACK -> pair=2'b10 immediately (asynchronous), FIFO empty, busy=0.
